// File: rtl/input_flow_handler_mc.sv
// input_flow_handler_mc: multi-channel two-phase token ingress with credit banking, ack toggle and sticky error flags
module input_flow_handler_mc #(
  parameter int CHANNELS = 4,
  parameter int DEPTH = 4,
  parameter int SYNC_STAGES = 2,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic                   clka,
  input  logic                   rsta,
  input  logic [CHANNELS-1:0]    diff_pair_p,
  input  logic [CHANNELS-1:0]    diff_pair_n,
  input  logic [CHANNELS-1:0]    token_pop,
  input  logic                   error_clr,
  output logic [CHANNELS-1:0]    token_valid,
  output logic [CHANNELS-1:0]    pipe_en,
  output logic [CHANNELS-1:0]    ack_toggle,
  output logic [CHANNELS*CW-1:0] token_count,
  output logic [CHANNELS-1:0]    overflow_err,
  output logic [CHANNELS-1:0]    phase_err
);
  logic [CHANNELS-1:0] w_ps, w_ns, r_p, r_n, w_arr, w_perr, w_full, w_ovf;
  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign w_ps = diff_pair_p;
      assign w_ns = diff_pair_n;
    end else begin : g_sync
      logic [CHANNELS-1:0] r_sp [SYNC_STAGES];
      logic [CHANNELS-1:0] r_sn [SYNC_STAGES];
      always_ff @(posedge clka or posedge rsta) begin
        if (rsta) begin
          for (int i = 0; i < SYNC_STAGES; i++) begin
            r_sp[i] <= '1;
            r_sn[i] <= '0;
          end
        end else begin
          r_sp[0] <= diff_pair_p;
          r_sn[0] <= diff_pair_n;
          for (int i = 1; i < SYNC_STAGES; i++) begin
            r_sp[i] <= r_sp[i-1];
            r_sn[i] <= r_sn[i-1];
          end
        end
      end
      assign w_ps = r_sp[SYNC_STAGES-1];
      assign w_ns = r_sn[SYNC_STAGES-1];
    end
  endgenerate
  // a token is both wires moving away from the stored phase; one wire alone is a protocol error
  assign w_arr = (w_ps ^ r_p) & (w_ns ^ r_n);
  assign w_perr = (w_ps ^ r_p) ^ (w_ns ^ r_n);
  assign pipe_en = token_pop & token_valid;
  assign w_ovf = w_arr & ~pipe_en & w_full;
  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) begin
      r_p <= '1;
      r_n <= '0;
      ack_toggle <= '0;
      overflow_err <= '0;
      phase_err <= '0;
    end else begin
      r_p <= w_ps;
      r_n <= w_ns;
      ack_toggle <= ack_toggle ^ pipe_en;
      overflow_err <= w_ovf | (overflow_err & ~{CHANNELS{error_clr}});
      phase_err <= w_perr | (phase_err & ~{CHANNELS{error_clr}});
    end
  end
  genvar c;
  generate
    for (c = 0; c < CHANNELS; c++) begin : g_ch
      logic [CW-1:0] r_cnt;
      assign w_full[c] = r_cnt == CW'(DEPTH);
      assign token_valid[c] = r_cnt != '0;
      assign token_count[c*CW +: CW] = r_cnt;
      always_ff @(posedge clka or posedge rsta) begin
        if (rsta) r_cnt <= '0;
        else if (w_arr[c] & ~pipe_en[c] & ~w_full[c]) r_cnt <= r_cnt + 1'b1;
        else if (~w_arr[c] & pipe_en[c]) r_cnt <= r_cnt - 1'b1;
      end
    end
  endgenerate
endmodule

// File: doc/input_flow_handler_mc.md
Name: input_flow_handler_mc

Overview:
- Multi-channel, parametrised successor to the single-pair input flow handler.
- Each channel receives two-phase (transition-signalled) tokens on a p/n pair. A valid token is both wires toggling relative to the stored phase.
- Tokens are banked in a per-channel credit counter and released to the pipeline on a local pop.
- A two-phase acknowledge toggle is returned per channel, and protocol errors are flagged.
- Sits at the link ingress, between the inter-node wires and the first pipeline stage.

Parameters:
- CHANNELS, 4, number of independent p/n token channels (1..16).
- DEPTH, 4, max banked tokens per channel (1..15). Counter width CW = clog2(DEPTH+1).
- SYNC_STAGES, 2, synchroniser flops on each p/n input (0, 2 or 3). 0 means inputs are already synchronous.

Ports:
- clka  input  1  clock.
- rsta  input  1  reset, asynchronous, active-high.
- diff_pair_p  input  CHANNELS  token wire p per channel.
- diff_pair_n  input  CHANNELS  token wire n per channel.
- token_pop  input  CHANNELS  pipeline requests one token per channel.
- error_clr  input  1  clears all sticky error bits.
- token_valid  output  CHANNELS  channel holds at least one banked token.
- pipe_en  output  CHANNELS  token consumed this cycle (token_valid & token_pop).
- ack_toggle  output  CHANNELS  two-phase ack, toggles once per consumed token.
- token_count  output  CHANNELS*CW  banked count per channel, channel c at [c*CW +: CW].
- overflow_err  output  CHANNELS  sticky: token arrived while full.
- phase_err  output  CHANNELS  sticky: only one wire of the pair toggled.

Behaviour:
- Reset (async assert, sync-to-clka release):
  - all p sync flops and p phase regs = 1; all n sync flops and n phase regs = 0;
  - counts = 0, ack_toggle = 0, both error vectors = 0;
  - token_valid = 0, pipe_en = 0.
- Synchroniser:
  - ps/ns are the final sync stage outputs, or the raw inputs when SYNC_STAGES = 0.
- Per channel, combinational each cycle:
  - dp = ps ^ p_reg; dn = ns ^ n_reg.
  - arrive = dp & dn.
  - perr = dp ^ dn.
- Phase regs:
  - on arrive or perr, p_reg <= ps and n_reg <= ns (resynchronise);
  - otherwise hold.
- Pop:
  - pop_ok = token_pop & (count != 0).
  - pipe_en = pop_ok, combinational, same cycle.
  - token_pop while count == 0 is ignored: no pipe_en, no ack.
- Counter update at clka edge:
  - arrive & !pop_ok & count < DEPTH: count + 1.
  - arrive & !pop_ok & count == DEPTH: token dropped, count holds, overflow_err set.
  - !arrive & pop_ok: count − 1.
  - arrive & pop_ok: count unchanged. Never an overflow, even when full.
  - perr: no count change from arrival; phase_err set.
- ack_toggle inverts on every edge where pop_ok = 1.
- token_valid = (count != 0), registered-count based.
- Latency:
  - a legal toggle sampled by clka edge k raises token_valid after edge k + SYNC_STAGES;
  - with SYNC_STAGES = 0, token_valid rises after the edge that samples the toggle.
- Errors:
  - error_clr clears all bits at the next edge;
  - a set and a clear on the same edge: set wins.
- Channels are fully independent; no arbitration between channels.
- Reset mid-operation: banked tokens are discarded and phases return to p=1/n=0. The sender must also be reset.

Test Plan:
- Reset, CHANNELS=4, SYNC_STAGES=2, all inputs idle at p=1/n=0 -> token_valid=0, counts=0, errors=0, ack_toggle=0.
- Ch0: toggle p and n together (p=0/n=1) at edge k -> token_valid[0]=1 after edge k+2, count=1. Then pop -> pipe_en[0]=1 that cycle, ack_toggle[0]=1, count=0.
- Ch1: 5 legal toggles with DEPTH=4, no pops -> count=4 and overflow_err[1]=1. Then 4 pops -> 4 pipe_en pulses, ack_toggle[1] toggles 4 times back to 0.
- Ch2 full (count=4): toggle arrives on the same cycle as a pop -> count stays 4, overflow_err[2]=0, pipe_en[2]=1.
- Ch3: only p toggles -> phase_err[3]=1, count unchanged. A following both-wire toggle is counted as a token. error_clr then clears phase_err; if error_clr coincides with a new perr, phase_err stays 1.
- Pop on an empty channel -> pipe_en=0, ack unchanged. Assert rsta asynchronously while counts are nonzero -> all outputs go to reset values without waiting for clka.
